pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the multicycle CPU, successor to the basic write-enabled PC register. It holds the current fetch address, and selects the next PC from increment, branch target, jump target or a hardware return-address stack (RAS). It resolves conditional writes from the ALU zero flag in either BEQ or BNE sense, and flags misaligned targets and stack underflow. It sits between the control FSM/ALU and the instruction-memory address port.

## Interface
- WIDTH, 32, PC and target width in bits
- RESET_VECTOR, 0, PC value loaded on reset; must be INC-aligned
- INC, 4, sequential increment in bytes; power of two, at least 1
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset; all state is cleared while low
- pc_write  in  1  unconditional PC update request
- pc_write_cond  in  1  conditional update request (branch)
- cond_invert  in  1  0: take when zero=1 (BEQ); 1: take when zero=0 (BNE)
- zero  in  1  ALU zero flag
- pc_src  in  2  next-PC select: 00 PC+INC, 01 branch_target, 10 jump_target, 11 RAS pop
- branch_target  in  WIDTH  branch destination
- jump_target  in  WIDTH  jump destination
- link  in  1  on an accepted update, push PC+INC onto the RAS (call)
- err_clr  in  1  synchronous clear of both sticky error flags
- pc_addr  out  WIDTH  current PC (registered)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- err_misalign  out  1  sticky: a misaligned target was rejected
- err_underflow  out  1  sticky: a pop from an empty RAS was rejected

## Operation
- Request: req = pc_write | (pc_write_cond & (zero ^ cond_invert)).
- Candidate value: cand = mux(pc_src) of PC+INC, branch_target, jump_target, RAS top.
- PC+INC wraps modulo 2^WIDTH.
- Reject conditions when req=1:
  - pc_src=11 with the RAS empty: reject and set err_underflow.
  - cand[log2(INC)-1:0] != 0: reject and set err_misalign. Does not apply when INC=1.
  - If both conditions apply, only err_underflow is set.
- A rejected request leaves the PC and the RAS unchanged.
- Accepted request (req=1 and not rejected): pc_addr <= cand.
- RAS is a circular buffer with a top pointer and an occupancy count (0..RAS_DEPTH).
- Pop (accepted, pc_src=11, link=0): count decrements; the top pointer moves to the previous entry.
- Push (accepted, link=1, pc_src!=11): the old PC+INC is written above the top; count increments, saturating at RAS_DEPTH.
- When the RAS is full, a push overwrites the oldest entry and count stays at RAS_DEPTH.
- Pop and link together (accepted, pc_src=11, link=1): the target is the old top; the top entry is replaced by the old PC+INC; count is unchanged.
- link with req=0 or with a rejected request: no push.
- err_clr=1 clears both error flags at the edge. If a new error occurs in the same cycle, setting wins.
- pc_write_cond while pc_write=1 is don't-care: the update is unconditional.

## Timing
- Reset (reset=0, asynchronous): pc_addr=RESET_VECTOR, RAS count=0, ras_empty=1, ras_full=0, both error flags 0. Stack contents are don't-care.
- Reset takes effect immediately, mid-operation included. The first update can occur at the first rising edge after reset deasserts.
- Latency is one cycle: inputs sampled at rising edge N determine pc_addr, the RAS and the flags immediately after edge N.
- ras_empty and ras_full are decoded from the registered count. No outputs have combinational paths from inputs.
- Back-to-back accepted updates on every cycle are supported. There is no handshake and no stall.
- Error flags hold until err_clr or reset.

## Test plan
- Reset and increment: deassert reset, then pc_write=1, pc_src=00 for 3 cycles -> pc_addr 0, 4, 8, 12. Assert reset mid-run -> pc_addr=0 immediately, without waiting for a clock.
- Conditional branch: pc_write_cond=1, pc_src=01, branch_target=0x40, zero=1, cond_invert=0 -> PC=0x40. Repeat with cond_invert=1 -> PC unchanged.
- Call/return: at PC=0x10, pc_src=10, jump_target=0x100, link=1 -> PC=0x100, ras_empty=0. Then pc_src=11 -> PC=0x14, ras_empty=1.
- RAS overflow (RAS_DEPTH=4): 5 calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> ras_full=1. The 4 pops return 0x404, 0x304, 0x204, 0x104. A 5th pop is rejected: err_underflow=1 and PC is unchanged.
- Misalignment: pc_write=1, pc_src=10, jump_target=0x102 -> PC unchanged, err_misalign=1. Then err_clr=1 -> flag cleared.
- Wrap: PC=0xFFFFFFFC, pc_write=1, pc_src=00 -> PC=0x00000000. With pc_src=11 and link=1 at a depth of 2 -> PC=old top, count stays 2, new top=0x0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address from increment, branch,
// jump or a circular return-address stack, with sticky misalign/underflow flags.
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                INC          = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             cond_invert,
  input  logic             zero,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             link,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pc_addr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             err_misalign,
  output logic             err_underflow
);

  localparam int               PW         = $clog2(RAS_DEPTH);
  localparam int               CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]    CNT_MAX    = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INC_V      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_mis_q, err_mis_d;
  logic             err_und_q, err_und_d;

  logic [WIDTH-1:0] pc_inc, cand;
  logic             req, rej_und, rej_mis, accept;
  logic             do_push, do_pop, do_swap, wr_en;
  logic [PW-1:0]    wr_idx;

  always_comb begin
    pc_inc = pc_q + INC_V;
    req    = pc_write | (pc_write_cond & (zero ^ cond_invert));

    case (pc_src)
      2'b00:   cand = pc_inc;
      2'b01:   cand = branch_target;
      2'b10:   cand = jump_target;
      default: cand = ras_q[top_q];
    endcase

    // Underflow takes priority so a pop from an empty stack never flags misalign.
    rej_und = req & (pc_src == 2'b11) & (cnt_q == '0);
    rej_mis = req & ~rej_und & ((cand & ALIGN_MASK) != '0);
    accept  = req & ~rej_und & ~rej_mis;

    do_push = accept & link & (pc_src != 2'b11);
    do_pop  = accept & ~link & (pc_src == 2'b11);
    do_swap = accept & link & (pc_src == 2'b11);

    pc_d   = accept ? cand : pc_q;
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = do_push | do_swap;
    wr_idx = top_q;

    if (do_push) begin
      top_d  = top_q + PW'(1);
      wr_idx = top_q + PW'(1);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end
    if (do_pop) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end

    err_mis_d = (err_mis_q & ~err_clr) | rej_mis;
    err_und_d = (err_und_q & ~err_clr) | rej_und;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_VECTOR;
      top_q     <= '0;
      cnt_q     <= '0;
      err_mis_q <= 1'b0;
      err_und_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      err_mis_q <= err_mis_d;
      err_und_q <= err_und_d;
    end
  end

  // Stack storage needs no reset; its contents are only read when count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_idx] <= pc_inc;
  end

  assign pc_addr       = pc_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_MAX);
  assign err_misalign  = err_mis_q;
  assign err_underflow = err_und_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a queue-based return-stack model.
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        pc_write, pc_write_cond, cond_invert, zero, link, err_clr;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_addr;
  logic        ras_empty, ras_full, err_misalign, err_underflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_mis, m_und;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_invert(cond_invert),
    .zero(zero), .pc_src(pc_src), .branch_target(branch_target),
    .jump_target(jump_target), .link(link), .err_clr(err_clr),
    .pc_addr(pc_addr), .ras_empty(ras_empty), .ras_full(ras_full),
    .err_misalign(err_misalign), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_mis = 1'b0;
    m_und = 1'b0;
  endtask

  // Behavioural rules: stack is a queue of return addresses, newest at the back.
  task automatic model_step();
    logic        req;
    logic [31:0] nxt, cand;
    req = pc_write | (pc_write_cond & (zero != cond_invert));
    nxt = m_pc + 32'd4;
    if (err_clr) begin
      m_mis = 1'b0;
      m_und = 1'b0;
    end
    if (req) begin
      if (pc_src == 2'd3 && m_ras.size() == 0) begin
        m_und = 1'b1;
      end else begin
        case (pc_src)
          2'd0: cand = nxt;
          2'd1: cand = branch_target;
          2'd2: cand = jump_target;
          default: cand = m_ras[m_ras.size()-1];
        endcase
        if (cand % 4 != 0) begin
          m_mis = 1'b1;
        end else begin
          if (pc_src == 2'd3 && link) m_ras[m_ras.size()-1] = nxt;
          else if (pc_src == 2'd3) void'(m_ras.pop_back());
          else if (link) begin
            m_ras.push_back(nxt);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
          m_pc = cand;
        end
      end
    end
  endtask

  task automatic cycle(input logic w, input logic wc, input logic ci, input logic z,
                       input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt,
                       input logic lk, input logic ec);
    pc_write = w; pc_write_cond = wc; cond_invert = ci; zero = z;
    pc_src = src; branch_target = bt; jump_target = jt; link = lk; err_clr = ec;
    model_step();
    @(posedge clk);
    #1;
    pc_write = 0; pc_write_cond = 0; link = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc_write = 0; pc_write_cond = 0; cond_invert = 0; zero = 0; pc_src = 0;
    branch_target = 0; jump_target = 0; link = 0; err_clr = 0;
    model_reset();
    #12;
    checks++;
    if ({pc_addr, ras_empty, ras_full, err_misalign, err_underflow} !== {32'h0, 4'b1000}) begin
      errors++;
      $display("[TB] FAIL reset_state got pc=%h e=%b f=%b m=%b u=%b", pc_addr, ras_empty,
               ras_full, err_misalign, err_underflow);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      checks++;
      if (pc_addr !== 32'(i * 4)) begin
        errors++;
        $display("[TB] FAIL increment_%0d got %h want %h", i, pc_addr, 32'(i * 4));
      end
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h want 0", pc_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_branch();
    cycle(0, 1, 0, 1, 2'd1, 32'h40, 0, 0, 0);
    checks++;
    if (pc_addr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL beq_taken got %h want 40", pc_addr);
    end
    cycle(0, 1, 1, 1, 2'd1, 32'h80, 0, 0, 0);
    checks++;
    if (pc_addr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL bne_not_taken got %h want 40", pc_addr);
    end
    cycle(0, 1, 1, 0, 2'd1, 32'h80, 0, 0, 0);
    checks++;
    if (pc_addr !== 32'h80) begin
      errors++;
      $display("[TB] FAIL bne_taken got %h want 80", pc_addr);
    end
  endtask

  task automatic test_call_return();
    do_reset();
    cycle(1, 0, 0, 0, 2'd2, 0, 32'h10, 0, 0);
    cycle(1, 0, 0, 0, 2'd2, 0, 32'h100, 1, 0);
    checks++;
    if ({pc_addr, ras_empty} !== {32'h100, 1'b0}) begin
      errors++;
      $display("[TB] FAIL call got pc=%h e=%b want 100/0", pc_addr, ras_empty);
    end
    cycle(1, 0, 0, 0, 2'd3, 0, 0, 0, 0);
    checks++;
    if ({pc_addr, ras_empty} !== {32'h14, 1'b1}) begin
      errors++;
      $display("[TB] FAIL return got pc=%h e=%b want 14/1", pc_addr, ras_empty);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104};
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1, 0, 0, 0, 2'd2, 0, 32'(i * 32'h100), 1, 0);
    checks++;
    if (ras_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ras_full got %b want 1", ras_full);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 2'd3, 0, 0, 0, 0);
      checks++;
      if (pc_addr !== exp_ret[i]) begin
        errors++;
        $display("[TB] FAIL pop_%0d got %h want %h", i, pc_addr, exp_ret[i]);
      end
    end
    cycle(1, 0, 0, 0, 2'd3, 0, 0, 0, 0);
    checks++;
    if ({pc_addr, err_underflow, err_misalign} !== {32'h104, 2'b10}) begin
      errors++;
      $display("[TB] FAIL underflow got pc=%h u=%b m=%b want 104/1/0", pc_addr,
               err_underflow, err_misalign);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    cycle(1, 0, 0, 0, 2'd2, 0, 32'h102, 1, 0);
    checks++;
    if ({pc_addr, err_misalign, ras_empty} !== {32'h0, 2'b11}) begin
      errors++;
      $display("[TB] FAIL misalign got pc=%h m=%b e=%b want 0/1/1", pc_addr, err_misalign,
               ras_empty);
    end
    cycle(0, 0, 0, 0, 2'd0, 0, 0, 0, 1);
    checks++;
    if (err_misalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clr got %b want 0", err_misalign);
    end
    cycle(1, 0, 0, 0, 2'd1, 32'h3, 0, 0, 1);
    checks++;
    if (err_misalign !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_wins got %b want 1", err_misalign);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1, 0, 0, 0, 2'd2, 0, 32'hFFFF_FFFC, 0, 0);
    cycle(1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    checks++;
    if (pc_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL inc_wrap got %h want 0", pc_addr);
    end
    cycle(1, 0, 0, 0, 2'd2, 0, 32'h100, 1, 0);
    cycle(1, 0, 0, 0, 2'd2, 0, 32'hFFFF_FFFC, 1, 0);
    cycle(1, 0, 0, 0, 2'd3, 0, 0, 1, 0);
    checks++;
    if ({pc_addr, ras_empty, ras_full} !== {32'h104, 2'b00}) begin
      errors++;
      $display("[TB] FAIL pop_link got pc=%h e=%b f=%b want 104/0/0", pc_addr, ras_empty,
               ras_full);
    end
    cycle(1, 0, 0, 0, 2'd3, 0, 0, 0, 0);
    checks++;
    if (pc_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL new_top got %h want 0", pc_addr);
    end
    cycle(1, 0, 0, 0, 2'd3, 0, 0, 0, 0);
    checks++;
    if ({pc_addr, ras_empty} !== {32'h4, 1'b1}) begin
      errors++;
      $display("[TB] FAIL bottom_entry got pc=%h e=%b want 4/1", pc_addr, ras_empty);
    end
  endtask

  task automatic test_random();
    logic [31:0] bt, jt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bt = {$urandom_range(0, 32'h3FFF), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00};
      jt = {$urandom_range(0, 32'h3FFF), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00};
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), bt, jt, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
      checks++;
      if ({pc_addr, ras_empty, ras_full, err_misalign, err_underflow} !==
          {m_pc, m_ras.size() == 0, m_ras.size() == DEPTH, m_mis, m_und}) begin
        errors++;
        $display("[TB] FAIL random_%0d got pc=%h e=%b f=%b m=%b u=%b want pc=%h n=%0d m=%b u=%b",
                 n, pc_addr, ras_empty, ras_full, err_misalign, err_underflow,
                 m_pc, m_ras.size(), m_mis, m_und);
      end
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_branch();
    test_call_return();
    test_overflow();
    test_misalign();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
